// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the LEGv8 hazard/forwarding controller.
package hazard_pkg;

    localparam int REG_W    = 5;
    localparam int ZERO_REG = 31;

    // Operand source select for the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // One scoreboard slot: the destination-side view of an in-flight instruction.
    typedef struct packed {
        logic [REG_W-1:0] Rd;
        logic             RegWrite;
        logic             Mem2Reg;
        logic             setsFlags;
    } sb_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } lu_state_t;

    // A bubble writes nothing, loads nothing and leaves the flags alone.
    localparam sb_entry_t SB_BUBBLE = '{
        Rd:        REG_W'(ZERO_REG),
        RegWrite:  1'b0,
        Mem2Reg:   1'b0,
        setsFlags: 1'b0
    };

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request / control-output bundle between the pipeline and the controller.
import hazard_pkg::*;

interface hazard_fwd_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] id_Rn;
    logic [REG_BITS-1:0] id_Rm;
    logic                id_usesRn;
    logic                id_usesRm;
    logic [REG_BITS-1:0] id_Rd;
    logic                id_RegWrite;
    logic                id_Mem2Reg;
    logic                id_setsFlags;
    logic                id_isBcond;

    fwd_sel_t            fwdA;
    fwd_sel_t            fwdB;
    logic                stall;
    logic                ex_noop;
    logic                flagSel;
    logic [CNT_BITS-1:0] stall_count;
    sb_entry_t           dbg_wb;

    // Pipeline side: presents the decoded ID instruction, consumes controls.
    modport master (
        output id_Rn, id_Rm, id_usesRn, id_usesRm, id_Rd,
               id_RegWrite, id_Mem2Reg, id_setsFlags, id_isBcond,
        input  fwdA, fwdB, stall, ex_noop, flagSel, stall_count, dbg_wb
    );

    // Controller side.
    modport slave (
        input  id_Rn, id_Rm, id_usesRn, id_usesRm, id_Rd,
               id_RegWrite, id_Mem2Reg, id_setsFlags, id_isBcond,
        output fwdA, fwdB, stall, ex_noop, flagSel, stall_count, dbg_wb
    );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Per-operand match against the EX and MEM scoreboard slots.
module fwd_match
    import hazard_pkg::*;
#(
    parameter logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG)
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  sb_entry_t        ex_i,
    input  sb_entry_t        mem_i,
    output fwd_sel_t         sel_o,
    output logic             load_haz_o
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    // MEM-slot load/flag bits do not influence operand selection.
    logic unused_bits;
    assign unused_bits = ^{mem_i.Mem2Reg, mem_i.setsFlags, ex_i.setsFlags};

    assign src_live = used_i && (src_i != ZERO_IDX);
    assign ex_hit   = src_live && ex_i.RegWrite  && (ex_i.Rd  == src_i);
    assign mem_hit  = src_live && mem_i.RegWrite && (mem_i.Rd == src_i);

    // Youngest producer wins; a load in EX has no result yet and must stall instead.
    always_comb begin
        sel_o      = FWD_REG;
        load_haz_o = 1'b0;
        if (ex_hit && !ex_i.Mem2Reg) begin
            sel_o = FWD_EX;
        end else if (mem_hit) begin
            sel_o = FWD_MEM;
        end
        load_haz_o = ex_hit && ex_i.Mem2Reg;
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding control for the 5-stage LEGv8 pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; a load-use hit stalls combinationally here
// LU_STALL | bubble from a load-use stall is now in EX; back to RUN
module hazard_fwd_ctrl #(
    parameter int REG_BITS = hazard_pkg::REG_W,
    parameter int ZERO_REG = hazard_pkg::ZERO_REG,
    parameter int CNT_BITS = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_fwd_if.slave  bus
);
    import hazard_pkg::*;

    sb_entry_t           ex_q, ex_d;
    sb_entry_t           mem_q;
    sb_entry_t           wb_q;
    lu_state_t           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    fwd_sel_t            sel_a, sel_b;
    logic                haz_a, haz_b;
    logic                load_use;

    fwd_match #(.ZERO_IDX(REG_BITS'(ZERO_REG))) u_match_a (
        .src_i      (bus.id_Rn),
        .used_i     (bus.id_usesRn),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_a),
        .load_haz_o (haz_a)
    );

    fwd_match #(.ZERO_IDX(REG_BITS'(ZERO_REG))) u_match_b (
        .src_i      (bus.id_Rm),
        .used_i     (bus.id_usesRm),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_b),
        .load_haz_o (haz_b)
    );

    assign load_use = haz_a || haz_b;

    // Next-state and control outputs; the stall is raised in the detecting cycle itself.
    always_comb begin
        state_d     = state_q;
        bus.stall   = 1'b0;
        bus.ex_noop = 1'b0;
        case (state_q)
            RUN: begin
                if (load_use) begin
                    state_d = LU_STALL;
                end
            end
            LU_STALL: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (load_use) begin
            bus.stall   = 1'b1;
            bus.ex_noop = 1'b1;
        end
    end

    // ID fields enter EX unless the instruction is being held for a load-use stall.
    always_comb begin
        ex_d = SB_BUBBLE;
        if (!load_use) begin
            ex_d.Rd        = bus.id_Rd;
            ex_d.RegWrite  = bus.id_RegWrite;
            ex_d.Mem2Reg   = bus.id_Mem2Reg;
            ex_d.setsFlags = bus.id_setsFlags;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_use && (cnt_q != {CNT_BITS{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Scoreboard shift, FSM and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= SB_BUBBLE;
            mem_q   <= SB_BUBBLE;
            wb_q    <= SB_BUBBLE;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fwdA        = sel_a;
    assign bus.fwdB        = sel_b;
    assign bus.flagSel     = bus.id_isBcond && ex_q.setsFlags;
    assign bus.stall_count = cnt_q;
    assign bus.dbg_wb      = wb_q;

endmodule
